// File: rtl/match_referee.sv
// Match referee: scores counter rounds, decides best-of match, restarts the counter between rounds.
// Latency: scores/match result registered on the round-end edge; restart pulse RESTART_GAP edges later.
// Backpressure: none; gameover is a level and round ends are ignored outside WAIT.
module match_referee #(
  parameter int WINS_TO_MATCH = 3,
  parameter int RESTART_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gameover,
  input  logic [1:0] who,
  input  logic       clear,
  output logic       round_restart,
  output logic       round_init,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] round_num,
  output logic       match_over,
  output logic [1:0] match_winner
);

  localparam logic [3:0] WINS = 4'(WINS_TO_MATCH);
  localparam logic [7:0] GAP  = 8'(RESTART_GAP);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_GAP,
    ST_RESTART,
    ST_INIT,
    ST_DONE
  } state_t;

  state_t     state, state_nxt;
  logic       gameover_q;
  logic       round_end;
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic [3:0] score_a_nxt, score_b_nxt, round_num_nxt;
  logic       match_over_nxt;
  logic [1:0] match_winner_nxt;
  logic       round_restart_nxt, round_init_nxt;

  // Only the rising edge of the gameover level marks a finished round.
  assign round_end = gameover & ~gameover_q;

  // Next-state, scoring and pulse decode; clear overrides everything, including a same-edge round end.
  always_comb begin
    state_nxt        = state;
    gap_cnt_nxt      = gap_cnt;
    score_a_nxt      = score_a;
    score_b_nxt      = score_b;
    round_num_nxt    = round_num;
    match_over_nxt   = match_over;
    match_winner_nxt = match_winner;

    case (state)
      ST_WAIT: begin
        if (round_end) begin
          if (who == 2'b01) begin
            score_a_nxt = score_a + 4'd1;
          end else if (who == 2'b10) begin
            score_b_nxt = score_b + 4'd1;
          end
          if (round_num != 4'hF) begin
            round_num_nxt = round_num + 4'd1;
          end
          if ((who == 2'b01 && score_a_nxt == WINS) ||
              (who == 2'b10 && score_b_nxt == WINS)) begin
            state_nxt        = ST_DONE;
            match_over_nxt   = 1'b1;
            match_winner_nxt = who;
          end else begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = GAP;
          end
        end
      end
      ST_GAP: begin
        gap_cnt_nxt = gap_cnt - 8'd1;
        if (gap_cnt_nxt == 8'd0) begin
          state_nxt = ST_RESTART;
        end
      end
      ST_RESTART: state_nxt = ST_INIT;
      ST_INIT:    state_nxt = ST_WAIT;
      ST_DONE:    state_nxt = ST_DONE;
      default:    state_nxt = ST_WAIT;
    endcase

    if (clear) begin
      state_nxt        = ST_RESTART;
      score_a_nxt      = 4'd0;
      score_b_nxt      = 4'd0;
      round_num_nxt    = 4'd0;
      match_over_nxt   = 1'b0;
      match_winner_nxt = 2'b00;
    end

    // Pulses are registered alongside the state they belong to, so they can never overlap.
    round_restart_nxt = (state_nxt == ST_RESTART);
    round_init_nxt    = (state_nxt == ST_INIT);
  end

  // State and output registers; reset aborts any pending restart sequence immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_WAIT;
      gameover_q    <= 1'b0;
      gap_cnt       <= 8'd0;
      score_a       <= 4'd0;
      score_b       <= 4'd0;
      round_num     <= 4'd0;
      match_over    <= 1'b0;
      match_winner  <= 2'b00;
      round_restart <= 1'b0;
      round_init    <= 1'b0;
    end else begin
      state         <= state_nxt;
      gameover_q    <= gameover;
      gap_cnt       <= gap_cnt_nxt;
      score_a       <= score_a_nxt;
      score_b       <= score_b_nxt;
      round_num     <= round_num_nxt;
      match_over    <= match_over_nxt;
      match_winner  <= match_winner_nxt;
      round_restart <= round_restart_nxt;
      round_init    <= round_init_nxt;
    end
  end

endmodule

// File: tb/tb_match_referee.sv
// Testbench for match_referee: scoreboard of expected outputs and expected restart/init pulse edges.
// Latency: outputs compared one edge after each stimulus; pulses compared when the DUT raises them.
// Backpressure: none; stimulus paced by fixed cycle counts with a global timeout.
module tb_match_referee;

  localparam int W = 3;
  localparam int G = 4;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] rn;
    logic       over;
    logic [1:0] win;
  } snap_t;

  logic       clk;
  logic       reset;
  logic       gameover;
  logic [1:0] who;
  logic       clear;
  logic       round_restart;
  logic       round_init;
  logic [3:0] score_a;
  logic [3:0] score_b;
  logic [3:0] round_num;
  logic       match_over;
  logic [1:0] match_winner;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  snap_t exp_out[$];
  int    exp_rst[$];
  int    exp_init[$];

  logic [3:0] m_a, m_b, m_rn;
  logic       m_over;
  logic [1:0] m_win;

  match_referee #(.WINS_TO_MATCH(W), .RESTART_GAP(G)) dut (
    .clk          (clk),
    .reset        (reset),
    .gameover     (gameover),
    .who          (who),
    .clear        (clear),
    .round_restart(round_restart),
    .round_init   (round_init),
    .score_a      (score_a),
    .score_b      (score_b),
    .round_num    (round_num),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: after edge e, cyc == e.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero();
    m_a = 4'd0; m_b = 4'd0; m_rn = 4'd0; m_over = 1'b0; m_win = 2'b00;
  endtask

  task automatic push_snap();
    snap_t s;
    s.a = m_a; s.b = m_b; s.rn = m_rn; s.over = m_over; s.win = m_win;
    exp_out.push_back(s);
  endtask

  task automatic pop_compare();
    snap_t s;
    if (exp_out.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    s = exp_out.pop_front();
    chk("score_a",      32'(score_a),      32'(s.a));
    chk("score_b",      32'(score_b),      32'(s.b));
    chk("round_num",    32'(round_num),    32'(s.rn));
    chk("match_over",   32'(match_over),   32'(s.over));
    chk("match_winner", 32'(match_winner), 32'(s.win));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_score_a"},   32'(score_a),       32'd0);
    chk({tag, "_score_b"},   32'(score_b),       32'd0);
    chk({tag, "_round_num"}, 32'(round_num),     32'd0);
    chk({tag, "_over"},      32'(match_over),    32'd0);
    chk({tag, "_winner"},    32'(match_winner),  32'd0);
    chk({tag, "_restart"},   32'(round_restart), 32'd0);
    chk({tag, "_init"},      32'(round_init),    32'd0);
  endtask

  // Drive one round end while the referee is in WAIT, then play out the restart sequence.
  task automatic do_round(input logic [1:0] w);
    logic fin;
    int   k;
    k = cyc + 1;
    if (w == 2'b01) m_a = m_a + 4'd1;
    else if (w == 2'b10) m_b = m_b + 4'd1;
    if (m_rn != 4'hF) m_rn = m_rn + 4'd1;
    fin = (w == 2'b01 && m_a == 4'(W)) || (w == 2'b10 && m_b == 4'(W));
    if (fin) begin
      m_over = 1'b1;
      m_win  = w;
    end
    gameover = 1'b1;
    who      = w;
    push_snap();
    if (!fin) begin
      exp_rst.push_back(k + G);
      exp_init.push_back(k + G + 1);
    end
    tick();
    pop_compare();
    if (!fin) begin
      repeat (G) tick();
      gameover = 1'b0;
      who      = 2'b00;
      tick();
      tick();
    end
  endtask

  // Pulse monitor: every restart/init pulse must match a scheduled edge.
  always @(negedge clk) begin
    if (round_restart || round_init)
      chk("pulse_exclusive", 32'(round_restart & round_init), 32'd0);
    if (round_restart) begin
      if (exp_rst.size() == 0) chk("restart_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else chk("restart_edge", 32'(cyc), 32'(exp_rst.pop_front()));
    end
    if (round_init) begin
      if (exp_init.size() == 0) chk("init_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      else chk("init_edge", 32'(cyc), 32'(exp_init.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset    = 1'b0;
    gameover = 1'b0;
    who      = 2'b00;
    clear    = 1'b0;
    model_zero();
    repeat (2) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Single round to A, then a void round.
    do_round(2'b01);
    do_round(2'b11);

    // B takes three rounds and the match.
    do_round(2'b10);
    do_round(2'b10);
    do_round(2'b10);

    // Further round ends in DONE change nothing and trigger no restart.
    repeat (3) tick();
    gameover = 1'b0;
    tick();
    gameover = 1'b1;
    who      = 2'b01;
    push_snap();
    tick();
    pop_compare();
    repeat (G + 3) tick();
    push_snap();
    pop_compare();

    // Clear out of DONE.
    k        = cyc + 1;
    clear    = 1'b1;
    gameover = 1'b0;
    who      = 2'b00;
    model_zero();
    push_snap();
    exp_rst.push_back(k);
    exp_init.push_back(k + 1);
    tick();
    clear = 1'b0;
    pop_compare();
    tick();
    tick();

    // Clear on the same edge as a round end: the round is not scored.
    k        = cyc + 1;
    clear    = 1'b1;
    gameover = 1'b1;
    who      = 2'b01;
    push_snap();
    exp_rst.push_back(k);
    exp_init.push_back(k + 1);
    tick();
    clear = 1'b0;
    pop_compare();
    gameover = 1'b0;
    who      = 2'b00;
    tick();
    tick();
    push_snap();
    pop_compare();

    // Reset asserted during GAP aborts at once with no restart pulse.
    k        = cyc + 1;
    m_a      = 4'd1;
    m_rn     = 4'd1;
    gameover = 1'b1;
    who      = 2'b01;
    push_snap();
    exp_rst.push_back(k + G);
    exp_init.push_back(k + G + 1);
    tick();
    pop_compare();
    tick();
    tick();
    reset    = 1'b0;
    gameover = 1'b0;
    who      = 2'b00;
    exp_rst.delete();
    exp_init.delete();
    model_zero();
    #1;
    chk_all_zero("async_reset");
    repeat (G + 3) tick();
    reset = 1'b1;
    tick();
    do_round(2'b10);

    repeat (3) tick();
    chk("pending_restart", 32'(exp_rst.size()), 32'd0);
    chk("pending_init",    32'(exp_init.size()), 32'd0);
    chk("pending_outputs", 32'(exp_out.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
